neo_bus_switch: RTL and testbench

- Clocked, parametrised successor to the NEO-G0 data bus switch.
- Connects one host data bus (68k side) to NCH device buses.
  - Per-byte-lane enables.
  - Fixed-priority channel grant.
  - Break-before-make turnaround on every grant or direction change.
  - Sticky conflict flag.
- Sits between the CPU data bus and cartridge/memory data buses.
- Tristate buffers live in the pad wrapper; this block drives only data and output-enable signals.

---
 rtl/neo_bus_switch.sv | 180 ++++++++++++++++++
 tb/tb_neo_bus_switch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_bus_switch.sv
// Clocked host/device data bus switch: fixed-priority channel grant, per-lane
// output enables, break-before-make turnaround and a sticky conflict flag.
module neo_bus_switch #(
  parameter int WIDTH       = 16,
  parameter int NCH         = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NCH-1:0]         nCE,
  input  logic                   RD,
  input  logic [WIDTH/8-1:0]     LANE,
  input  logic [WIDTH-1:0]       A_IN,
  output logic [WIDTH-1:0]       A_OUT,
  output logic [WIDTH/8-1:0]     A_OE,
  input  logic [NCH*WIDTH-1:0]   D_IN,
  output logic [WIDTH-1:0]       D_OUT,
  output logic [NCH*WIDTH/8-1:0] D_OE,
  output logic [NCH-1:0]         GRANT,
  output logic                   CONFLICT,
  input  logic                   CONFLICT_CLR
);

  localparam int L  = WIDTH / 8;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TURN  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam bit         NO_TURN   = (TURN_CYCLES == 0);
  localparam logic [2:0] TURN_LOAD = NO_TURN ? 3'd0 : 3'(TURN_CYCLES - 1);

  logic [1:0]          r_state;
  logic [CW-1:0]       r_gch;
  logic                r_gdir;
  logic [2:0]          r_cnt;

  logic [WIDTH-1:0]    r_a_out_p1;
  logic [L-1:0]        r_a_oe_p1;
  logic [WIDTH-1:0]    r_d_out_p1;
  logic [NCH*L-1:0]    r_d_oe_p1;
  logic [NCH-1:0]      r_grant_p1;
  logic                r_conflict;

  logic                w_req;
  logic                w_multi;
  logic [CW-1:0]       w_sel;

  logic [1:0]          w_state_nx;
  logic [CW-1:0]       w_gch_nx;
  logic                w_gdir_nx;
  logic [2:0]          w_cnt_nx;
  logic                w_drive;
  logic                w_ctx_chg;
  logic [1:0]          w_data_st;

  logic [WIDTH-1:0]    w_rd_data;
  logic [NCH*L-1:0]    w_d_oe_nx;
  logic [NCH-1:0]      w_grant_nx;
  logic                w_rd_drive;
  logic                w_wr_drive;

  // Request decode: scanning from the top leaves the lowest requester in w_sel.
  always_comb begin
    w_req   = 1'b0;
    w_multi = 1'b0;
    w_sel   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (!nCE[k]) begin
        if (w_req) w_multi = 1'b1;
        w_req = 1'b1;
        w_sel = CW'(k);
      end
    end
  end

  always_comb begin
    w_ctx_chg  = (w_sel != r_gch) || (RD != r_gdir);
    w_data_st  = RD ? S_READ : S_WRITE;
    w_state_nx = r_state;
    w_gch_nx   = r_gch;
    w_gdir_nx  = r_gdir;
    w_cnt_nx   = r_cnt;
    w_drive    = 1'b0;
    if (!w_req) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_gch_nx  = w_sel;
          w_gdir_nx = RD;
          w_cnt_nx  = TURN_LOAD;
          if (NO_TURN) begin
            w_state_nx = w_data_st;
            w_drive    = 1'b1;
          end else begin
            w_state_nx = S_TURN;
          end
        end
        S_TURN: begin
          if (w_ctx_chg) begin
            w_gch_nx   = w_sel;
            w_gdir_nx  = RD;
            w_cnt_nx   = TURN_LOAD;
            w_state_nx = NO_TURN ? w_data_st : S_TURN;
          end else if (r_cnt == 3'd0) begin
            w_state_nx = w_data_st;
            w_drive    = 1'b1;
          end else begin
            w_cnt_nx = r_cnt - 3'd1;
          end
        end
        default: begin
          // A context change always spends this edge with every OE low.
          if (w_ctx_chg) begin
            w_gch_nx   = w_sel;
            w_gdir_nx  = RD;
            w_cnt_nx   = TURN_LOAD;
            w_state_nx = NO_TURN ? w_data_st : S_TURN;
          end else begin
            w_drive = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_rd_drive = w_drive && (w_state_nx == S_READ);
    w_wr_drive = w_drive && (w_state_nx == S_WRITE);
    w_rd_data  = '0;
    w_d_oe_nx  = '0;
    w_grant_nx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_gch_nx == CW'(k)) begin
        w_rd_data = D_IN[k*WIDTH +: WIDTH];
        if (w_wr_drive) w_d_oe_nx[k*L +: L] = LANE;
        if (w_state_nx != S_IDLE) w_grant_nx[k] = 1'b1;
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_gch      <= '0;
      r_gdir     <= 1'b0;
      r_cnt      <= 3'd0;
      r_a_out_p1 <= '0;
      r_a_oe_p1  <= '0;
      r_d_out_p1 <= '0;
      r_d_oe_p1  <= '0;
      r_grant_p1 <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_gch      <= w_gch_nx;
      r_gdir     <= w_gdir_nx;
      r_cnt      <= w_cnt_nx;
      r_grant_p1 <= w_grant_nx;
      r_d_oe_p1  <= w_d_oe_nx;
      r_a_oe_p1  <= w_rd_drive ? LANE : '0;
      if (w_rd_drive) r_a_out_p1 <= w_rd_data;
      if (w_wr_drive) r_d_out_p1 <= A_IN;
      if (w_multi) r_conflict <= 1'b1;
      else if (CONFLICT_CLR) r_conflict <= 1'b0;
    end
  end

  assign A_OUT    = r_a_out_p1;
  assign A_OE     = r_a_oe_p1;
  assign D_OUT    = r_d_out_p1;
  assign D_OE     = r_d_oe_p1;
  assign GRANT    = r_grant_p1;
  assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_neo_bus_switch.sv
// Bench for neo_bus_switch: three parameter sets share one stimulus stream and
// are checked every cycle against a behavioural model plus literal expectations.
module tb_neo_bus_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, clr, en;
  logic [3:0]  nce;
  logic [1:0]  lane;
  logic [15:0] a_in;
  logic [63:0] d_in;

  logic [15:0] a_out0, d_out0, a_out1, d_out1, a_out2, d_out2;
  logic [1:0]  a_oe0, a_oe1, a_oe2;
  logic [3:0]  d_oe0, d_oe2;
  logic [7:0]  d_oe1;
  logic [1:0]  gnt0, gnt2;
  logic [3:0]  gnt1;
  logic        cf0, cf1, cf2;

  int total = 0;
  int bad   = 0;

  neo_bus_switch #(.WIDTH(16), .NCH(2), .TURN_CYCLES(1)) u0 (
    .CLK(clk), .RESET(rst), .nCE(nce[1:0]), .RD(rd), .LANE(lane), .A_IN(a_in),
    .A_OUT(a_out0), .A_OE(a_oe0), .D_IN(d_in[31:0]), .D_OUT(d_out0), .D_OE(d_oe0),
    .GRANT(gnt0), .CONFLICT(cf0), .CONFLICT_CLR(clr));

  neo_bus_switch #(.WIDTH(16), .NCH(4), .TURN_CYCLES(3)) u1 (
    .CLK(clk), .RESET(rst), .nCE(nce), .RD(rd), .LANE(lane), .A_IN(a_in),
    .A_OUT(a_out1), .A_OE(a_oe1), .D_IN(d_in), .D_OUT(d_out1), .D_OE(d_oe1),
    .GRANT(gnt1), .CONFLICT(cf1), .CONFLICT_CLR(clr));

  neo_bus_switch #(.WIDTH(16), .NCH(2), .TURN_CYCLES(0)) u2 (
    .CLK(clk), .RESET(rst), .nCE(nce[1:0]), .RD(rd), .LANE(lane), .A_IN(a_in),
    .A_OUT(a_out2), .A_OE(a_oe2), .D_IN(d_in[31:0]), .D_OUT(d_out2), .D_OE(d_oe2),
    .GRANT(gnt2), .CONFLICT(cf2), .CONFLICT_CLR(clr));

  // phase: 0 = nobody owns the bus, 1 = dead cycles, 2 = data flowing
  typedef struct {
    int          phase;
    int          ch;
    bit          dir;
    int          dead;
    logic [15:0] a_out;
    logic [15:0] d_out;
    logic [1:0]  a_oe;
    logic [15:0] d_oe;
    logic [7:0]  grant;
    bit          conflict;
  } mdl_t;

  mdl_t m0, m1, m2;

  function automatic mdl_t step(mdl_t s, int nch, int turn);
    mdl_t n;
    int   lows;
    int   first;
    bit   same;
    bit   drive;
    n = s;
    if (rst) begin
      n.phase = 0; n.ch = 0; n.dir = 0; n.dead = 0;
      n.a_out = '0; n.d_out = '0; n.a_oe = '0; n.d_oe = '0;
      n.grant = '0; n.conflict = 0;
      return n;
    end
    lows  = 0;
    first = -1;
    for (int k = 0; k < nch; k++) begin
      if (!nce[k]) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    if (lows > 1) n.conflict = 1;
    else if (clr) n.conflict = 0;
    n.a_oe  = '0;
    n.d_oe  = '0;
    n.grant = '0;
    drive   = 0;
    if (first < 0) begin
      n.phase = 0;
      return n;
    end
    same = (first == s.ch) && (rd == s.dir);
    if (s.phase == 0 || !same) begin
      n.ch   = first;
      n.dir  = rd;
      n.dead = turn - 1;
      if (turn == 0) begin
        n.phase = 2;
        drive   = (s.phase == 0);
      end else begin
        n.phase = 1;
      end
    end else if (s.phase == 1) begin
      if (s.dead == 0) begin
        n.phase = 2;
        drive   = 1;
      end else begin
        n.dead = s.dead - 1;
      end
    end else begin
      drive = 1;
    end
    n.grant = 8'(1) << n.ch;
    if (drive) begin
      if (n.dir) begin
        n.a_out = d_in[n.ch*16 +: 16];
        n.a_oe  = lane;
      end else begin
        n.d_out = a_in;
        n.d_oe[n.ch*2 +: 2] = lane;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    m0 = step(m0, 2, 1);
    m1 = step(m1, 4, 3);
    m2 = step(m2, 2, 0);
  end

  always @(negedge clk) begin
    if (en) begin
      chk("u0_a_out", a_out0, m0.a_out);
      chk("u0_a_oe",  a_oe0,  m0.a_oe);
      chk("u0_d_out", d_out0, m0.d_out);
      chk("u0_d_oe",  d_oe0,  m0.d_oe);
      chk("u0_grant", gnt0,   m0.grant);
      chk("u0_conf",  cf0,    m0.conflict);
      chk("u0_bbm",   64'((a_oe0 != 0) && (d_oe0 != 0)), 64'd0);
      chk("u1_a_out", a_out1, m1.a_out);
      chk("u1_a_oe",  a_oe1,  m1.a_oe);
      chk("u1_d_out", d_out1, m1.d_out);
      chk("u1_d_oe",  d_oe1,  m1.d_oe);
      chk("u1_grant", gnt1,   m1.grant);
      chk("u1_conf",  cf1,    m1.conflict);
      chk("u1_bbm",   64'((a_oe1 != 0) && (d_oe1 != 0)), 64'd0);
      chk("u2_a_out", a_out2, m2.a_out);
      chk("u2_a_oe",  a_oe2,  m2.a_oe);
      chk("u2_d_out", d_out2, m2.d_out);
      chk("u2_d_oe",  d_oe2,  m2.d_oe);
      chk("u2_grant", gnt2,   m2.grant);
      chk("u2_conf",  cf2,    m2.conflict);
      chk("u2_bbm",   64'((a_oe2 != 0) && (d_oe2 != 0)), 64'd0);
    end
  end

  initial begin
    en = 0; rst = 1; nce = 4'hF; rd = 0; lane = 2'b00; a_in = '0; d_in = '0; clr = 0;
    tick();
    en = 1;
    tick();
    chk("rst_a_oe",  a_oe0,  0);
    chk("rst_d_oe",  d_oe0,  0);
    chk("rst_grant", gnt0,   0);
    chk("rst_conf",  cf0,    0);
    chk("rst_a_out", a_out0, 0);
    chk("rst_d_out", d_out0, 0);

    // Read on ch0
    rst = 0;
    d_in = {32'h7E81_3C3C, 16'h5AA5, 16'hA55A};
    nce = 4'b1110; rd = 1; lane = 2'b11;
    tick();
    chk("t1_turn_grant", gnt0, 2'b01);
    chk("t1_turn_a_oe",  a_oe0, 0);
    chk("t1_turn_d_oe",  d_oe0, 0);
    chk("t6_direct_a_oe",  a_oe2, 2'b11);
    chk("t6_direct_a_out", a_out2, 16'hA55A);
    tick();
    chk("t1_read_a_oe",  a_oe0, 2'b11);
    chk("t1_read_a_out", a_out0, 16'hA55A);
    chk("t1_read_grant", gnt0, 2'b01);

    // Direction flip on ch0
    rd = 0; a_in = 16'hBEEF;
    tick();
    chk("t4_flip_a_oe", a_oe0, 0);
    chk("t4_flip_d_oe", d_oe0, 0);
    tick();
    chk("t4_write_d_oe",  d_oe0, 4'b0011);
    chk("t4_write_d_out", d_out0, 16'hBEEF);
    chk("t4_write_a_oe",  a_oe0, 0);

    // Write lower lane on ch1
    nce = 4'b1101; lane = 2'b01; a_in = 16'h1234;
    tick();
    chk("t2_turn_d_oe",  d_oe0, 0);
    chk("t2_turn_grant", gnt0, 2'b10);
    tick();
    chk("t2_write_d_oe",  d_oe0, 4'b0100);
    chk("t2_write_d_out", d_out0, 16'h1234);
    chk("t2_write_a_oe",  a_oe0, 0);
    nce = 4'hF;
    tick();
    chk("rel_grant", gnt0, 0);
    chk("rel_d_oe",  d_oe0, 0);
    chk("rel_hold",  d_out0, 16'h1234);

    // Conflict and priority
    nce = 4'b1100; rd = 1; lane = 2'b11;
    tick();
    chk("t3_conf_set", cf0, 1);
    chk("t3_prio",     gnt0, 2'b01);
    nce = 4'b1110;
    tick();
    chk("t3_conf_stay", cf0, 1);
    chk("t3_grant",     gnt0, 2'b01);
    tick();
    chk("t3_conf_stay2", cf0, 1);
    clr = 1;
    tick();
    chk("t3_conf_clr", cf0, 0);
    nce = 4'b1100;
    tick();
    chk("t3_set_wins", cf0, 1);
    nce = 4'b1110;
    tick();
    chk("t3_clr_again", cf0, 0);
    clr = 0;

    // Write on ch2 of the four-channel, three-turn instance, then reset
    nce = 4'b1011; rd = 0; lane = 2'b11; a_in = 16'hCAFE;
    tick(); tick(); tick();
    chk("t5_turn_d_oe",  d_oe1, 0);
    chk("t5_turn_grant", gnt1, 4'b0100);
    tick();
    chk("t5_write_d_oe",  d_oe1, 8'h30);
    chk("t5_write_d_out", d_out1, 16'hCAFE);
    rst = 1;
    tick();
    chk("t5_rst_d_oe",  d_oe1, 0);
    chk("t5_rst_grant", gnt1, 0);
    chk("t5_rst_d_out", d_out1, 0);
    rst = 0;
    tick();
    chk("t5_re_grant", gnt1, 4'b0100);
    chk("t5_re_d_oe1", d_oe1, 0);
    tick(); tick();
    chk("t5_re_d_oe3", d_oe1, 0);
    tick();
    chk("t5_re_write", d_oe1, 8'h30);

    // Zero-turnaround switching ch1 -> ch0
    nce = 4'hF;
    tick();
    nce = 4'b1101; rd = 1; lane = 2'b11;
    tick();
    chk("t6_ch1_a_oe",  a_oe2, 2'b11);
    chk("t6_ch1_a_out", a_out2, 16'h5AA5);
    chk("t6_ch1_grant", gnt2, 2'b10);
    nce = 4'b1110;
    tick();
    chk("t6_gap_a_oe",  a_oe2, 0);
    chk("t6_gap_grant", gnt2, 2'b01);
    chk("t6_gap_hold",  a_out2, 16'h5AA5);
    tick();
    chk("t6_ch0_a_oe",  a_oe2, 2'b11);
    chk("t6_ch0_a_out", a_out2, 16'hA55A);

    // Lane changes without turnaround; a disabled lane still updates data
    for (int i = 0; i < 3; i++) begin
      lane = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b00;
      d_in[15:0] = 16'h1111 * 16'(i + 1);
      tick();
    end
    chk("lane_off_a_oe",  a_oe2, 0);
    chk("lane_off_a_out", a_out2, 16'h3333);
    nce = 4'hF;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
